// File: rtl/serial_to_parallel.sv
// Serial-to-parallel deserializer: LSB-first bit stream in, valid/ready word out with overflow flag.
// Optional even-parity trailer bit per frame when SERIAL_TO_PARALLEL_PARITY_EN is defined.
module serial_to_parallel #(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             serial_valid,
  input  logic             serial_data,
  input  logic             parallel_ready,
  output logic             parallel_valid,
  output logic [width-1:0] parallel_data,
  output logic             busy,
  output logic             overflow,
  output logic             parity_error
);

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
  localparam int unsigned par_bits = 1;
`else
  localparam int unsigned par_bits = 0;
`endif
  localparam int unsigned frame_len = width + par_bits;
  localparam int unsigned cnt_w     = $clog2(frame_len);
  localparam logic [cnt_w-1:0] last_idx = cnt_w'(frame_len - 1);

  logic [cnt_w-1:0] cnt_q, cnt_c;
  logic [width-1:0] shreg_q, shreg_c;
  logic             last_c;
  logic             load_c;

  // Bit capture: each valid bit lands at the position given by the counter
  always_comb begin
    shreg_c = shreg_q;
    cnt_c   = cnt_q;
    last_c  = 1'b0;
    if (serial_valid) begin
      for (int unsigned i = 0; i < width; i++) begin
        if (cnt_q == cnt_w'(i)) shreg_c[i] = serial_data;
      end
      last_c = (cnt_q == last_idx);
      cnt_c  = last_c ? '0 : cnt_q + cnt_w'(1);
    end
  end

  // A completed word loads only if the output slot is empty or being drained
  assign load_c = last_c && (!parallel_valid || parallel_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q          <= '0;
      shreg_q        <= '0;
      busy           <= 1'b0;
      overflow       <= 1'b0;
      parallel_valid <= 1'b0;
      parallel_data  <= '0;
    end else begin
      cnt_q    <= cnt_c;
      shreg_q  <= shreg_c;
      busy     <= (cnt_c != '0);
      overflow <= last_c && !load_c;
      if (load_c) begin
        parallel_valid <= 1'b1;
        parallel_data  <= shreg_c;
      end else if (parallel_ready) begin
        parallel_valid <= 1'b0;
      end
    end
  end

`ifdef SERIAL_TO_PARALLEL_PARITY_EN
  // Even parity: data bits XOR trailer bit must be 0; the trailer is never stored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_error <= 1'b0;
    end else if (load_c) begin
      parity_error <= (^shreg_q) ^ serial_data;
    end
  end
`else
  assign parity_error = 1'b0;
`endif

endmodule
